// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch PC, 2-entry prefetch queue and redirect handling
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [31:0]           rom_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_fault
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]           word_q [2];
  logic [31:0]           word_d [2];
  logic [ADDR_WIDTH-1:0] pc_q [2];
  logic [ADDR_WIDTH-1:0] pc_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  fault_q, fault_d;
  logic                  pop, push;

  assign pop = (count_q != 2'd0) && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    word_d     = word_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fault_d    = fault_q;
    push       = !fault_q && ((count_q != 2'd2) || pop);

    if (redirect) begin
      // Flush drops everything queued, including any pop offered this cycle.
      count_d = 2'd0;
      tail_d  = head_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end else begin
        fault_d    = 1'b0;
        fetch_pc_d = redirect_pc;
      end
`else
      fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
`endif
    end else begin
      if (push) begin
        word_d[tail_q] = rom_data;
        pc_d[tail_q]   = fetch_pc_q;
        tail_d         = ~tail_q;
        fetch_pc_d     = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        head_d = ~head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      word_q[0]  <= '0;
      word_q[1]  <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      word_q     <= word_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  assign rom_address = fetch_pc_q;
  assign inst_valid  = (count_q != 2'd0);
  assign inst        = word_q[head_q];
  assign inst_pc     = pc_q[head_q];
  assign fetch_fault = fault_q;

endmodule
